ekf_stage_sched: RTL and testbench

Parametrised stage scheduler that sits between the PS command interface and the RSA/NonLinear core.
- Queues EKF stage commands (predict / new-landmark / update) with their payloads in a FIFO.
- Dispatches them one at a time over the one-hot stage_val/stage_rdy handshake and holds the payload stable for the whole operation.
- Maintains landmark_num internally, validates each command before issue, and reports completion and sticky errors.

---
 rtl/ekf_sched_pkg.sv | 30 +++
 rtl/ekf_cmd_fifo.sv | 46 ++++
 rtl/ekf_stage_sched.sv | 154 +++++++++++++++
 tb/tb_ekf_stage_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ekf_sched_pkg.sv
// Shared stage codes, one-hot issue constants, error bit positions and FSM
// encoding for the EKF stage scheduler.
package ekf_sched_pkg;

    localparam logic [1:0] ST_PREDICT = 2'd0;
    localparam logic [1:0] ST_NEWLM   = 2'd1;
    localparam logic [1:0] ST_UPDATE  = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    localparam logic [2:0] OH_PREDICT = 3'b001;
    localparam logic [2:0] OH_NEWLM   = 3'b010;
    localparam logic [2:0] OH_UPDATE  = 3'b100;

    localparam int ERR_STAGE = 0;
    localparam int ERR_LK    = 1;
    localparam int ERR_OVF   = 2;
    localparam int ERR_TO    = 3;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} state_t;

    function automatic logic [2:0] stage_onehot(input logic [1:0] s);
        case (s)
            ST_PREDICT: stage_onehot = OH_PREDICT;
            ST_NEWLM:   stage_onehot = OH_NEWLM;
            ST_UPDATE:  stage_onehot = OH_UPDATE;
            default:    stage_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ekf_cmd_fifo.sv
// Synchronous command FIFO with show-ahead read port; push/pop are
// internally gated by full/empty.
module ekf_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/ekf_stage_sched.sv
// EKF stage scheduler: queues predict/newlm/update commands, validates them
// against the landmark count, and issues them one at a time to the core.
module ekf_stage_sched
    import ekf_sched_pkg::*;
#(
    parameter int DW      = 32,
    parameter int LM_AW   = 10,
    parameter int DEPTH   = 4,
    parameter int MAX_LM  = 2**LM_AW-1,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       sys_rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_stage,
    input  logic [LM_AW-1:0]           cmd_lk,
    input  logic [DW-1:0]              cmd_d0,
    input  logic [DW-1:0]              cmd_d1,
    output logic [2:0]                 stage_val,
    input  logic [2:0]                 stage_rdy,
    output logic [LM_AW-1:0]           landmark_num,
    output logic [LM_AW-1:0]           l_k,
    output logic [DW-1:0]              vlr,
    output logic [DW-1:0]              alpha,
    output logic [DW-1:0]              rk,
    output logic [DW-1:0]              phi,
    output logic                       done_valid,
    output logic [1:0]                 done_stage,
    output logic                       done_err,
    output logic [3:0]                 err_flags,
    input  logic                       err_clr,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     q_level
);

    localparam int FW = 2 + LM_AW + 2*DW;

    state_t            state;
    logic [1:0]        h_stage;
    logic [TO_W-1:0]   to_cnt;
    logic              rst_done;
    logic [FW-1:0]     f_rdata;
    logic              f_full, f_empty, f_pop;
    logic [1:0]        f_stage;
    logic [LM_AW-1:0]  f_lk;
    logic [DW-1:0]     f_d0, f_d1;
    logic              rdy_hit, to_hit, lm_full;
    logic [3:0]        err_set;

    // rst_done keeps cmd_ready low while reset is asserted.
    assign cmd_ready = rst_done && !f_full;
    assign f_pop     = (state == S_IDLE);
    assign busy      = (state != S_IDLE) || !f_empty;
    assign {f_stage, f_lk, f_d0, f_d1} = f_rdata;

    ekf_cmd_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .push  (cmd_valid && cmd_ready),
        .wdata ({cmd_stage, cmd_lk, cmd_d0, cmd_d1}),
        .pop   (f_pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty),
        .level (q_level)
    );

    assign rdy_hit = |(stage_rdy & stage_val);
    assign to_hit  = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT-1));
    assign lm_full = (landmark_num == LM_AW'(MAX_LM));

    always_comb begin
        err_set = '0;
        if (state == S_CHECK) begin
            err_set[ERR_STAGE] = (h_stage == ST_ILLEGAL);
            err_set[ERR_LK]    = (h_stage == ST_UPDATE) && (l_k >= landmark_num);
            err_set[ERR_OVF]   = (h_stage == ST_NEWLM) && lm_full;
        end
        if (state == S_WAIT)
            err_set[ERR_TO] = to_hit && !rdy_hit;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= S_IDLE;
            rst_done     <= 1'b0;
            h_stage      <= '0;
            to_cnt       <= '0;
            stage_val    <= '0;
            landmark_num <= '0;
            l_k          <= '0;
            vlr          <= '0;
            alpha        <= '0;
            rk           <= '0;
            phi          <= '0;
            done_valid   <= 1'b0;
            done_stage   <= '0;
            done_err     <= 1'b0;
            err_flags    <= '0;
        end else begin
            rst_done   <= 1'b1;
            done_valid <= 1'b0;
            err_flags  <= (err_clr ? 4'b0 : err_flags) | err_set;
            case (state)
                S_IDLE: if (!f_empty) begin
                    h_stage <= f_stage;
                    case (f_stage)
                        ST_PREDICT: begin vlr <= f_d0; alpha <= f_d1; end
                        ST_NEWLM:   begin rk <= f_d0; phi <= f_d1; l_k <= landmark_num; end
                        ST_UPDATE:  begin rk <= f_d0; phi <= f_d1; l_k <= f_lk; end
                        default: ;
                    endcase
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (|err_set) begin
                        done_valid <= 1'b1;
                        done_err   <= 1'b1;
                        done_stage <= h_stage;
                        state      <= S_IDLE;
                    end else begin
                        stage_val <= stage_onehot(h_stage);
                        to_cnt    <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A matching rdy on the timeout edge still counts as success.
                    if (rdy_hit) begin
                        stage_val  <= '0;
                        if (h_stage == ST_NEWLM && !lm_full)
                            landmark_num <= landmark_num + 1'b1;
                        done_valid <= 1'b1;
                        done_err   <= 1'b0;
                        done_stage <= h_stage;
                        state      <= S_IDLE;
                    end else if (to_hit) begin
                        stage_val  <= '0;
                        done_valid <= 1'b1;
                        done_err   <= 1'b1;
                        done_stage <= h_stage;
                        state      <= S_IDLE;
                    end else if (TIMEOUT != 0) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Directed bench for ekf_stage_sched: issue timing, landmark bookkeeping,
// validation errors, FIFO backpressure, timeout and mid-operation reset.
module tb_ekf_stage_sched;

    localparam int DW = 32, LM_AW = 10, DEPTH = 4, QW = 3;

    logic             clk, sys_rst_n;
    logic             cmd_valid, cmd_ready;
    logic [1:0]       cmd_stage;
    logic [LM_AW-1:0] cmd_lk;
    logic [DW-1:0]    cmd_d0, cmd_d1;
    logic [2:0]       stage_val, stage_rdy;
    logic [LM_AW-1:0] landmark_num, l_k;
    logic [DW-1:0]    vlr, alpha, rk, phi;
    logic             done_valid, done_err, err_clr, busy;
    logic [1:0]       done_stage;
    logic [3:0]       err_flags;
    logic [QW-1:0]    q_level;

    ekf_stage_sched #(.DW(DW), .LM_AW(LM_AW), .DEPTH(DEPTH), .TO_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_stage(cmd_stage),
        .cmd_lk(cmd_lk), .cmd_d0(cmd_d0), .cmd_d1(cmd_d1),
        .stage_val(stage_val), .stage_rdy(stage_rdy),
        .landmark_num(landmark_num), .l_k(l_k),
        .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi),
        .done_valid(done_valid), .done_stage(done_stage), .done_err(done_err),
        .err_flags(err_flags), .err_clr(err_clr), .busy(busy), .q_level(q_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, act, exp);
    endtask

    task automatic push(input logic [1:0] st, input logic [LM_AW-1:0] lk,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int n;
        cmd_stage = st; cmd_lk = lk; cmd_d0 = d0; cmd_d1 = d1; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) chk("push_ready_timeout", 0, 1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue(input string tag, input logic [2:0] exp);
        int n;
        n = 0;
        while (stage_val == 3'b0 && n < 20) begin @(negedge clk); n++; end
        chk(tag, stage_val, exp);
    endtask

    task automatic ack(input logic [2:0] bits, input logic [1:0] exp_st);
        stage_rdy = bits;
        @(posedge clk); @(negedge clk);
        stage_rdy = 3'b0;
        chk("ack_done_valid", done_valid, 1);
        chk("ack_done_err", done_err, 0);
        chk("ack_done_stage", done_stage, exp_st);
        chk("ack_stage_val_low", stage_val, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [2:0] sv_seen;
        logic dv_seen;
        sys_rst_n = 1'b0; cmd_valid = 1'b0; cmd_stage = '0; cmd_lk = '0;
        cmd_d0 = '0; cmd_d1 = '0; stage_rdy = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_stage_val", stage_val, 0);
        chk("rst_landmark_num", landmark_num, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q_level", q_level, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_err_flags", err_flags, 0);
        chk("rst_vlr", vlr, 0);
        sys_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // predict: stage_val rises exactly two edges after acceptance
        push(2'd0, '0, 32'h0001_0000, 32'h0000_8000);
        chk("pred_sv_e0", stage_val, 0);
        chk("pred_busy", busy, 1);
        @(negedge clk);
        chk("pred_sv_e1", stage_val, 0);
        chk("pred_vlr", vlr, 32'h0001_0000);
        chk("pred_alpha", alpha, 32'h0000_8000);
        @(negedge clk);
        chk("pred_sv_e2", stage_val, 3'b001);
        ack(3'b001, 2'd0);
        @(negedge clk);
        chk("pred_done_one_cycle", done_valid, 0);
        chk("pred_landmark_num", landmark_num, 0);

        // three back-to-back newlm commands
        for (int i = 0; i < 3; i++) push(2'd1, '0, 32'h100 + i, 32'h200 + i);
        chk("newlm_q_level", q_level, 2);
        chk("newlm_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            wait_issue("newlm_issue", 3'b010);
            chk("newlm_l_k", l_k, i);
            chk("newlm_rk", rk, 32'h100 + i);
            chk("newlm_phi", phi, 32'h200 + i);
            chk("newlm_q_drain", q_level, 2 - i);
            repeat (5) @(negedge clk);
            chk("newlm_held", stage_val, 3'b010);
            ack(3'b010, 2'd1);
        end
        chk("newlm_landmark_num", landmark_num, 3);

        // update out of range rejected, then in range issued
        push(2'd2, 10'd3, 32'hAA, 32'hBB);
        sv_seen = '0; n = 0;
        while (!done_valid && n < 20) begin sv_seen |= stage_val; @(negedge clk); n++; end
        chk("upd_bad_done", done_valid, 1);
        chk("upd_bad_err", done_err, 1);
        chk("upd_bad_stage", done_stage, 2);
        chk("upd_bad_flags", err_flags, 4'b0010);
        chk("upd_bad_no_issue", sv_seen | stage_val, 0);
        push(2'd2, 10'd2, 32'hCC, 32'hDD);
        wait_issue("upd_issue", 3'b100);
        chk("upd_l_k", l_k, 2);
        chk("upd_rk", rk, 32'hCC);
        chk("upd_phi", phi, 32'hDD);
        ack(3'b100, 2'd2);
        chk("upd_flags_sticky", err_flags, 4'b0010);
        err_clr = 1'b1; @(posedge clk); @(negedge clk); err_clr = 1'b0;
        chk("err_clr", err_flags, 0);

        // fill FIFO while WAIT is stalled; extra command must survive
        push(2'd0, '0, 32'hA0, 32'h50);
        wait_issue("fill_issue0", 3'b001);
        for (int k = 1; k <= 4; k++) push(2'd0, '0, 32'hA0 + k, 32'h0);
        chk("fill_cmd_ready_low", cmd_ready, 0);
        chk("fill_q_level", q_level, 4);
        cmd_stage = 2'd0; cmd_d0 = 32'hA5; cmd_d1 = 32'h0; cmd_valid = 1'b1;
        stage_rdy = 3'b001;
        @(posedge clk); @(negedge clk);
        stage_rdy = 3'b0;
        chk("fill_ack0", done_valid, 1);
        chk("fill_q_still_full", q_level, 4);
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_issue("drain_issue", 3'b001);
            chk("drain_vlr", vlr, 32'hA0 + k);
            if (k == 2) begin
                stage_rdy = 3'b010;
                repeat (2) @(negedge clk);
                stage_rdy = 3'b0;
                chk("wrong_rdy_ignored", stage_val, 3'b001);
                chk("wrong_rdy_no_done", done_valid, 0);
            end
            ack(3'b001, 2'd0);
        end
        @(negedge clk);
        chk("drain_q_empty", q_level, 0);
        chk("drain_idle", busy, 0);

        // timeout after 8 WAIT edges
        push(2'd0, '0, 32'h1234, 32'h5678);
        wait_issue("to_issue", 3'b001);
        n = 0;
        do begin @(negedge clk); n++; end while (stage_val != 3'b0 && n < 20);
        chk("to_edges", n, 8);
        chk("to_done_valid", done_valid, 1);
        chk("to_done_err", done_err, 1);
        chk("to_flags", err_flags, 4'b1000);
        err_clr = 1'b1; @(posedge clk); @(negedge clk); err_clr = 1'b0;
        chk("to_err_clr", err_flags, 0);

        // reset mid-WAIT drops everything silently
        push(2'd2, 10'd0, 32'h1, 32'h2);
        wait_issue("rstw_issue", 3'b100);
        push(2'd0, '0, 32'h3, 32'h4);
        chk("rstw_q_level", q_level, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("rstw_stage_val", stage_val, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_q_level0", q_level, 0);
        chk("rstw_landmark_num", landmark_num, 0);
        @(negedge clk);
        sys_rst_n = 1'b1;
        dv_seen = 1'b0; sv_seen = '0;
        repeat (6) begin @(negedge clk); dv_seen |= done_valid; sv_seen |= stage_val; end
        chk("rstw_no_done", dv_seen, 0);
        chk("rstw_no_issue", sv_seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
